// File: rtl/pfiform_pkg.sv
// pfiform_pkg: shared widths and the pop-reader state encoding for the
// PFIFORM repacking FIFO side blocks.
package pfiform_pkg;

    localparam int ELEM_W = 6;                // bits per element
    localparam int ELEM_N = 32;               // elements per FIFO word
    localparam int AMT_W  = 5;                // chunk size minus one
    localparam int DATA_W = ELEM_W * ELEM_N;  // FIFO word width

    // Pop-reader sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } reader_state_e;

endpackage

// File: rtl/pfiform_pop_amt.sv
// pfiform_pop_amt: size of the next FIFO request, coded minus one.
// amt = min(remaining, chunk_max + 1) - 1, evaluated one bit wider than the
// length so chunk_max + 1 = 32 never wraps. Shared with the write-side
// sequencer.
module pfiform_pop_amt
    import pfiform_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic [LEN_W-1:0] remaining,
    input  logic [AMT_W-1:0] chunk_max,
    output logic [AMT_W-1:0] amt
);

    logic [LEN_W:0] rem_x;
    logic [LEN_W:0] lim_x;
    logic [LEN_W:0] min_x;

    // Clamp the request to what is left of the frame; result always fits AMT_W
    always_comb begin
        rem_x = {1'b0, remaining};
        lim_x = (LEN_W+1)'(chunk_max) + (LEN_W+1)'(1);
        min_x = (rem_x < lim_x) ? rem_x : lim_x;
        amt   = AMT_W'(min_x - (LEN_W+1)'(1));
    end

endmodule

// File: rtl/pfiform_pop_reader.sv
// pfiform_pop_reader: drains one programmed frame of elements from the
// PFIFORM pop port in chunks of 1..32 elements and hands each popped word
// downstream through a single-entry output buffer.
//
// Optional feature: define PFIFORM_POP_READER_TIMEOUT_EN to add a WAIT-state
// watchdog (TIMEOUT_CYC cycles) that aborts the frame and pulses err_timeout.
//
// Downstream handshake: o_valid/o_data/o_cnt/o_last are held stable while
// o_valid is high; a word transfers on any rising clock edge where
// o_valid && i_ready, and o_valid never depends combinationally on i_ready.
//
// FIFO side: PopPermit is a one-cycle request with PopAmout valid alongside;
// exactly one PopEnable beat answers it some cycles later. Only one request
// is ever outstanding and PopEnable outside WAIT is ignored.
module pfiform_pop_reader #(
    parameter int ELEM_W = 6,
    parameter int ELEM_N = 32,
    parameter int LEN_W  = 16
`ifdef PFIFORM_POP_READER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 256
`endif
) (
    input  logic                          i_core_clk,
    input  logic                          i_rx_rstn,
    input  logic                          frame_start,
    input  logic [LEN_W-1:0]              frame_len,
    input  logic [pfiform_pkg::AMT_W-1:0] chunk_max,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          PopPermit,
    output logic [pfiform_pkg::AMT_W-1:0] PopAmout,
    input  logic                          PopEnable,
    input  logic [ELEM_W*ELEM_N-1:0]      PopData,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [ELEM_W*ELEM_N-1:0]      o_data,
    output logic [pfiform_pkg::AMT_W-1:0] o_cnt,
    output logic                          o_last,
    output pfiform_pkg::reader_state_e    dbg_state
`ifdef PFIFORM_POP_READER_TIMEOUT_EN
    ,
    output logic                          err_timeout
`endif
);

    import pfiform_pkg::AMT_W;
    import pfiform_pkg::reader_state_e;
    import pfiform_pkg::IDLE;
    import pfiform_pkg::REQ;
    import pfiform_pkg::WAIT;
    import pfiform_pkg::HOLD;

`ifdef PFIFORM_POP_READER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]  wd_cnt_q;
`endif

    reader_state_e    state_q;
    logic [LEN_W-1:0] remaining_q;
    logic [AMT_W-1:0] chunk_max_q;

    logic [LEN_W-1:0] amt_rem;
    logic [AMT_W-1:0] amt_cmax;
    logic [AMT_W-1:0] amt_next;
    logic [LEN_W-1:0] chunk_len;

    assign dbg_state = state_q;

    // Elements covered by the request currently in flight
    assign chunk_len = LEN_W'(PopAmout) + LEN_W'(1);

    // Request sizing uses the live inputs when a frame starts, latched values after
    always_comb begin
        amt_rem  = remaining_q;
        amt_cmax = chunk_max_q;
        if (state_q == IDLE) begin
            amt_rem  = frame_len;
            amt_cmax = chunk_max;
        end
    end

    pfiform_pop_amt #(
        .LEN_W     (LEN_W)
    ) u_amt (
        .remaining (amt_rem),
        .chunk_max (amt_cmax),
        .amt       (amt_next)
    );

    // Frame sequencer: request, wait for the beat, hold it until accepted
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            chunk_max_q <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            PopPermit   <= 1'b0;
            PopAmout    <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_cnt       <= '0;
            o_last      <= 1'b0;
`ifdef PFIFORM_POP_READER_TIMEOUT_EN
            wd_cnt_q    <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            // pulse outputs default low every cycle
            PopPermit  <= 1'b0;
            frame_done <= 1'b0;
`ifdef PFIFORM_POP_READER_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        if (frame_len != '0) begin
                            remaining_q <= frame_len;
                            chunk_max_q <= chunk_max;
                            busy        <= 1'b1;
                            PopPermit   <= 1'b1;
                            PopAmout    <= amt_next;
                            state_q     <= REQ;
                        end else begin
                            // empty frame completes immediately
                            frame_done <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    // PopPermit is high for exactly this one cycle
                    state_q <= WAIT;
`ifdef PFIFORM_POP_READER_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                end

                WAIT: begin
                    if (PopEnable) begin
                        o_data      <= PopData;
                        o_cnt       <= PopAmout;
                        remaining_q <= remaining_q - chunk_len;
                        o_last      <= (remaining_q == chunk_len);
                        o_valid     <= 1'b1;
                        state_q     <= HOLD;
                    end
`ifdef PFIFORM_POP_READER_TIMEOUT_EN
                    else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        // FIFO never answered: abandon the frame
                        err_timeout <= 1'b1;
                        frame_done  <= 1'b1;
                        busy        <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
`endif
                end

                HOLD: begin
                    // o_valid is always high here; wait for the consumer
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        if (o_last) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            PopPermit <= 1'b1;
                            PopAmout  <= amt_next;
                            state_q   <= REQ;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pfiform_pop_reader.md
Name: pfiform_pop_reader

Overview:
- Pop-side reader/sequencer for the PFIFORM repacking FIFO.
- Drains one programmed frame of 6-bit elements from the FIFO in variable-size chunks. Each chunk is 1..32 elements, coded minus-one on PopAmout.
- Holds each popped 192-bit word in a single-entry output buffer and hands it downstream with valid/ready, count and last flags.
- Sits between the PFIFORM pop port and the downstream consumer, in the i_core_clk domain.

Parameters:
- ELEM_W, 6: bits per element.
- ELEM_N, 32: elements per PopData word; PopData width is ELEM_W*ELEM_N.
- LEN_W, 16: width of the frame length in elements.
- TIMEOUT_CYC, 256: watchdog limit in cycles; used only with the optional feature.

Ports:
- i_core_clk  in  1  clock.
- i_rx_rstn  in  1  reset, asynchronous, active-low. Single clock domain.
- frame_start  in  1  one-cycle pulse that starts a frame.
- frame_len  in  LEN_W  elements in the frame; sampled on frame_start.
- chunk_max  in  5  maximum chunk size minus one; sampled on frame_start.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse at frame completion.
- PopPermit  out  1  one-cycle pulse; each pulse is one pop request to the FIFO.
- PopAmout  out  5  elements requested minus one; valid in the PopPermit cycle.
- PopEnable  in  1  one-cycle FIFO response beat carrying PopData.
- PopData  in  ELEM_W*ELEM_N  popped elements; element 0 is in the LSBs.
- o_valid  out  1  output buffer holds data.
- i_ready  in  1  downstream accepts data.
- o_data  out  ELEM_W*ELEM_N  buffered word.
- o_cnt  out  5  valid elements in o_data minus one.
- o_last  out  1  buffered word is the final chunk of the frame.
- err_timeout  out  1  optional-feature output only.

Behaviour:
- Reset values: all outputs 0; state IDLE; remaining counter 0.
- FIFO protocol:
  - Each PopPermit pulse produces exactly one PopEnable beat, 1 or more cycles later.
  - At most one request is outstanding.
  - PopEnable outside WAIT is ignored.
- amt (per request) = min(remaining, chunk_max+1) - 1. Computed at LEN_W+1 bits; the result always fits in 5 bits.
- State IDLE:
  - frame_start with frame_len != 0: latch remaining, frame_len and chunk_max; set busy; go to REQ.
  - frame_start with frame_len == 0: frame_done pulses the next cycle; no PopPermit; stay in IDLE.
- State REQ:
  - PopPermit=1 and PopAmout=amt for exactly one cycle; go to WAIT.
- State WAIT:
  - On PopEnable: o_data<=PopData, o_cnt<=amt, remaining<=remaining-(amt+1).
  - o_last<=1 when the new remaining is 0.
  - o_valid<=1 the next cycle; go to HOLD.
- State HOLD:
  - o_data, o_cnt and o_last stay stable until o_valid && i_ready.
  - On that handshake, o_valid drops the next cycle.
  - If o_last: frame_done pulses in the same cycle the state returns to IDLE, and busy drops.
  - Otherwise go to REQ.
- No PopPermit is issued while the buffer is occupied.
- Minimum chunk period is 3 cycles: REQ, WAIT with 1-cycle latency, then HOLD with i_ready high.
- frame_start while busy is ignored; the in-flight frame is unaffected.
- frame_len and chunk_max changes mid-frame are ignored because the values are latched.
- Reset mid-frame:
  - Immediate return to IDLE with all outputs at 0.
  - Any outstanding FIFO response is dropped; the FIFO shares the reset.
- Unused upper elements of o_data above o_cnt carry whatever the FIFO supplied. Downstream uses o_cnt.

Optional Feature:
- Macro: PFIFORM_POP_READER_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in WAIT and clears on entry to WAIT.
  - When it reaches TIMEOUT_CYC without PopEnable: err_timeout pulses for 1 cycle, frame_done pulses, the block returns to IDLE, and o_valid stays 0.
  - A late PopEnable after the abort is ignored.
- Undefined: the err_timeout port and the counter are absent; WAIT waits indefinitely.

Decomposition:
- Package pfiform_pkg holds:
  - ELEM_W, ELEM_N, AMT_W=5 and DATA_W;
  - the reader state enum {IDLE, REQ, WAIT, HOLD}.
- Sub-module pfiform_pop_amt: combinational amt calculation, reused by the write-side sequencer. Everything else stays in the top module.

Test Plan:
- frame_len=64, chunk_max=31, FIFO latency 1, i_ready=1 -> two requests with PopAmout 31 and 31; o_last on the second beat; frame_done once; 6 cycles from frame_start to done.
- frame_len=45, chunk_max=18 -> PopAmout sequence 18, 18, 6; o_cnt matches each; o_last only with o_cnt=6.
- frame_len=0 -> frame_done 1 cycle after frame_start; PopPermit never asserted; busy stays 0.
- frame_len=3, chunk_max=0, i_ready held low 10 cycles after the first beat -> o_data stable and no PopPermit during the stall; then PopAmout 0, 0, 0 in sequence.
- Second frame_start mid-frame and reset asserted in WAIT -> the second start is ignored; after reset all outputs are 0 and a late PopEnable produces no o_valid.
- With PFIFORM_POP_READER_TIMEOUT_EN and the FIFO silent -> err_timeout and frame_done pulse exactly TIMEOUT_CYC=256 cycles after entering WAIT; state returns to IDLE.
